hazard_sb: RTL and testbench
============================

# hazard_sb

Scoreboard-based pipeline hazard controller for the IF1/IF2/ID/EX/MEM/WB core. It generalises the single-cycle load-use interlock to a configurable number of ID read ports and multi-cycle producer latencies of up to MAX_LAT cycles. It adds a data-SRAM-miss global stall and an instruction-miss state machine that discards a stale refill after a redirect. It sits beside the ID stage and drives the stall, flush and I-SRAM reset controls of every front-end pipeline register.

## Interface
- NRA, 2, number of ID-stage register read ports
- AW, 5, register address width (2**AW architectural registers; register 0 is never tracked)
- MAX_LAT, 4, largest producer latency, in cycles until the result can be forwarded to ID
- LW, $clog2(MAX_LAT+1), width of the latency fields

- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_we  in  1  ID instruction writes the register file
- id_wa  in  AW  ID destination register
- id_lat  in  LW  producer latency of the ID instruction: 0 = ALU, 1 = load, 2..MAX_LAT = mul/div
- id_re  in  NRA  per-port read enable
- id_ra  in  NRA*AW  read addresses, port k at [k*AW +: AW]
- npc_sel_ex  in  1  EX resolved a taken redirect
- inst_sram_miss  in  1  I-SRAM refill in progress
- data_sram_miss  in  1  D-SRAM miss in MEM
- stall_pc, stall_if1_if2, stall_if_id  out  1 each  hold the register
- flush_if1_if2, flush_if_id, flush_id_ex  out  1 each  bubble the register
- stall_all  out  1  freeze the whole pipeline
- inst_sram_rstn  out  1  active-low abort of the current I-SRAM access
- drop_refill  out  1  FSM is in state DROP

## Operation
- Scoreboard: one LW-bit countdown cnt[r] per register r = 1..2**AW-1. An entry is busy when cnt[r] != 0.
- Issue: `issue = id_valid & id_we & id_wa!=0 & ~stall_if_id & ~flush_id_ex & ~stall_all`.
  - On issue, `cnt[id_wa] <= max(id_lat, cnt[id_wa]-1)`. This guards WAW ordering.
  - Every other busy entry decrements by 1 each cycle unless stall_all is asserted.
- Data hazard: `raw = OR over k of (id_re[k] & id_ra[k]!=0 & cnt[id_ra[k]]!=0)`.
- Output priority, highest first; unlisted outputs are 0 and inst_sram_rstn is 1:
  1. data_sram_miss: stall_all = 1. Every other control is idle. Counters and the FSM are frozen.
  2. raw: stall_pc, stall_if1_if2, stall_if_id and flush_id_ex are asserted.
  3. npc_sel_ex: flush_if1_if2, flush_if_id and flush_id_ex are asserted, and inst_sram_rstn = 0.
  4. FSM = DROP: stall_pc, flush_if1_if2 and flush_if_id are asserted.
  5. inst_sram_miss: stall_pc, stall_if1_if2 and flush_if_id are asserted.
- I-fetch FSM (state type fetch_st_t):
  - RUN → MISS when inst_sram_miss = 1 and there is no redirect this cycle.
  - MISS → DROP when npc_sel_ex is accepted, i.e. priority 3 applied.
  - MISS → RUN when inst_sram_miss = 0.
  - DROP → RUN when inst_sram_miss = 0. The stale line is discarded and the PC keeps the redirect target.
  - A redirect accepted while in DROP stays in DROP.
- Reset (rstn = 0 at a clock edge): all cnt = 0 and FSM = RUN. While rstn = 0 all outputs are forced idle: stalls and flushes 0, stall_all 0, inst_sram_rstn 1, drop_refill 0. A reset in the middle of a miss abandons it.

## Timing
- All outputs are combinational from the inputs and registered state; there is zero-cycle response to a hazard.
- A producer issued with latency L blocks a dependent instruction in ID for exactly L cycles, plus any stall_all cycles in between.
  - L = 1 reproduces the classic one-bubble load-use interlock.
  - L = 0 never stalls.
- State updates occur on the rising edge of clk only.
- Redirect, FSM transitions and the scoreboard update in the same cycle as their qualifying inputs. The effect is visible in the next cycle.

## Structure
- hazard_pkg contains:
  - fetch_st_t, an enum with RUN, MISS and DROP
  - the default MAX_LAT
  - a function sat_dec(cnt) that decrements and saturates at 0
- Sub-module hazard_scoreboard(AW, LW, NRA) holds the counter array, the issue update and the raw reduction. hazard_sb wraps it together with the FSM and the priority logic.

## Test plan
- Load-use: issue lw to x5 with id_lat = 1, then a dependent add reading x5 on port 0. Required: exactly one cycle with stall_pc = stall_if_id = flush_id_ex = 1, then the add issues. With id_lat = 0 there are no stalls.
- Divider: issue id_lat = 4 to x7; the next instruction reads x7 on port 1. Required: 4 stall cycles. With data_sram_miss held for 3 of those cycles, the total is 7 stall cycles and stall_all is high for 3.
- Register 0: a producer writing x0 with id_lat = 4 and a reader of x0. Required: zero stalls and no scoreboard entry set.
- Redirect during miss: hold inst_sram_miss for 5 cycles and pulse npc_sel_ex in cycle 2. Required:
  - cycle 2: inst_sram_rstn = 0 and all three flushes asserted;
  - cycles 3-5: drop_refill = 1, stall_pc = 1, flush_if1_if2 = 1;
  - the cycle after inst_sram_miss falls: RUN, all outputs idle.
- Priority: assert raw, npc_sel_ex and inst_sram_miss together. Required: only the raw response. Adding data_sram_miss gives only stall_all.
- Reset mid-operation: with cnt[x3] = 3 and FSM = DROP, drive rstn = 0 for one edge. Required: a reader of x3 is not stalled, and drop_refill = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and helpers for the hazard scoreboard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

   localparam int MAX_LAT_DEF = 4;
   localparam int SAT_W       = 8;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      MISS = 2'd1,
      DROP = 2'd2
   } fetch_st_t;

   // Countdown step that sticks at zero; callers narrow the result to their width.
   function automatic logic [SAT_W-1:0] sat_dec(input logic [SAT_W-1:0] cnt);
      return (cnt == '0) ? cnt : cnt - SAT_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Per-register latency countdowns and the ID read-after-write check.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int AW  = 5,
   parameter int LW  = 3,
   parameter int NRA = 2
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_issue,
   input  logic              i_hold,
   input  logic [AW-1:0]     i_wa,
   input  logic [LW-1:0]     i_lat,
   input  logic [NRA-1:0]    i_re,
   input  logic [NRA*AW-1:0] i_ra,
   output logic              o_raw
);

   localparam int NREG = 2**AW;

   logic [NREG-1:0] w_busy;

   // x0 is hardwired, so it can never be a hazard source.
   assign w_busy[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_cnt
      logic [LW-1:0] r_cnt;
      logic [LW-1:0] w_dec;

      assign w_dec = LW'(sat_dec(SAT_W'(r_cnt)));

      always_ff @(posedge clk) begin
         if (!rstn) begin
            r_cnt <= '0;
         end else if (i_issue && (i_wa == AW'(r))) begin
            // Keep the longer of the new producer and any older one still in flight.
            r_cnt <= (i_lat > w_dec) ? i_lat : w_dec;
         end else if (!i_hold) begin
            r_cnt <= w_dec;
         end
      end

      assign w_busy[r] = |r_cnt;
   end

   always_comb begin
      o_raw = 1'b0;
      for (int k = 0; k < NRA; k++) begin
         o_raw = o_raw | (i_re[k] & w_busy[i_ra[k*AW +: AW]]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_sb.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sb
// Description : Front-end hazard controller: scoreboard interlock, redirect
//               flush, D-miss freeze and stale I-refill discard.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sb
   import hazard_pkg::*;
#(
   parameter int NRA     = 2,
   parameter int AW      = 5,
   parameter int MAX_LAT = MAX_LAT_DEF,
   parameter int LW      = $clog2(MAX_LAT + 1)
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              id_valid,
   input  logic              id_we,
   input  logic [AW-1:0]     id_wa,
   input  logic [LW-1:0]     id_lat,
   input  logic [NRA-1:0]    id_re,
   input  logic [NRA*AW-1:0] id_ra,
   input  logic              npc_sel_ex,
   input  logic              inst_sram_miss,
   input  logic              data_sram_miss,
   output logic              stall_pc,
   output logic              stall_if1_if2,
   output logic              stall_if_id,
   output logic              flush_if1_if2,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              stall_all,
   output logic              inst_sram_rstn,
   output logic              drop_refill
);

   fetch_st_t r_state;
   fetch_st_t w_state_nxt;
   logic      w_raw;
   logic      w_issue;
   logic      w_redir;

   assign w_issue = id_valid & id_we & (id_wa != '0) & ~stall_if_id & ~flush_id_ex & ~stall_all;

   hazard_scoreboard #(
      .AW  (AW),
      .LW  (LW),
      .NRA (NRA)
   ) u_scoreboard (
      .clk     (clk),
      .rstn    (rstn),
      .i_issue (w_issue),
      .i_hold  (stall_all),
      .i_wa    (id_wa),
      .i_lat   (id_lat),
      .i_re    (id_re),
      .i_ra    (id_ra),
      .o_raw   (w_raw)
   );

   // A redirect only takes effect when nothing of higher priority masks it.
   assign w_redir = npc_sel_ex & ~data_sram_miss & ~w_raw;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!data_sram_miss) begin
         case (r_state)
            RUN:     if (inst_sram_miss && !w_redir) w_state_nxt = MISS;
            MISS:    if (w_redir)                    w_state_nxt = DROP;
                     else if (!inst_sram_miss)       w_state_nxt = RUN;
            DROP:    if (!w_redir && !inst_sram_miss) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
         endcase
      end
   end

   always_comb begin
      stall_pc       = 1'b0;
      stall_if1_if2  = 1'b0;
      stall_if_id    = 1'b0;
      flush_if1_if2  = 1'b0;
      flush_if_id    = 1'b0;
      flush_id_ex    = 1'b0;
      stall_all      = 1'b0;
      inst_sram_rstn = 1'b1;
      drop_refill    = 1'b0;
      if (rstn) begin
         drop_refill = (r_state == DROP);
         if (data_sram_miss) begin
            stall_all = 1'b1;
         end else if (w_raw) begin
            stall_pc      = 1'b1;
            stall_if1_if2 = 1'b1;
            stall_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
         end else if (npc_sel_ex) begin
            flush_if1_if2  = 1'b1;
            flush_if_id    = 1'b1;
            flush_id_ex    = 1'b1;
            inst_sram_rstn = 1'b0;
         end else if (r_state == DROP) begin
            stall_pc      = 1'b1;
            flush_if1_if2 = 1'b1;
            flush_if_id   = 1'b1;
         end else if (inst_sram_miss) begin
            stall_pc      = 1'b1;
            stall_if1_if2 = 1'b1;
            flush_if_id   = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_sb
// Description : Self-checking bench for hazard_sb with a ready-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_sb;

   localparam int AW      = 5;
   localparam int NRA     = 2;
   localparam int MAX_LAT = 4;
   localparam int LW      = 3;

   // {stall_pc, stall_if1_if2, stall_if_id, flush_if1_if2, flush_if_id,
   //  flush_id_ex, stall_all, inst_sram_rstn, drop_refill}
   localparam logic [8:0] IDLE  = 9'b000_000_010;
   localparam logic [8:0] RAWO  = 9'b111_001_010;
   localparam logic [8:0] REDIR = 9'b000_111_000;
   localparam logic [8:0] DROPO = 9'b100_110_011;
   localparam logic [8:0] IMISS = 9'b110_010_010;
   localparam logic [8:0] SALL  = 9'b000_000_110;

   logic              clk = 1'b0;
   logic              rstn;
   logic              id_valid, id_we;
   logic [AW-1:0]     id_wa;
   logic [LW-1:0]     id_lat;
   logic [NRA-1:0]    id_re;
   logic [NRA*AW-1:0] id_ra;
   logic              npc_sel_ex, inst_sram_miss, data_sram_miss;
   logic              stall_pc, stall_if1_if2, stall_if_id;
   logic              flush_if1_if2, flush_if_id, flush_id_ex;
   logic              stall_all, inst_sram_rstn, drop_refill;

   hazard_sb #(.NRA(NRA), .AW(AW), .MAX_LAT(MAX_LAT), .LW(LW)) dut (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_we(id_we), .id_wa(id_wa),
      .id_lat(id_lat), .id_re(id_re), .id_ra(id_ra), .npc_sel_ex(npc_sel_ex),
      .inst_sram_miss(inst_sram_miss), .data_sram_miss(data_sram_miss),
      .stall_pc(stall_pc), .stall_if1_if2(stall_if1_if2), .stall_if_id(stall_if_id),
      .flush_if1_if2(flush_if1_if2), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .stall_all(stall_all), .inst_sram_rstn(inst_sram_rstn), .drop_refill(drop_refill)
   );

   wire [8:0] obs = {stall_pc, stall_if1_if2, stall_if_id, flush_if1_if2, flush_if_id,
                     flush_id_ex, stall_all, inst_sram_rstn, drop_refill};

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Reference model: a register is busy until the count of unfrozen cycles
   // reaches its ready time; the fetch side tracks "refill pending" and "refill stale".
   int tick = 0;
   int ready [32];
   bit m_pend  = 1'b0;
   bit m_stale = 1'b0;

   function automatic bit m_raw();
      for (int k = 0; k < NRA; k++) begin
         int ra;
         ra = int'(id_ra[k*AW +: AW]);
         if (id_re[k] && ra != 0 && ready[ra] > tick) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [8:0] m_out();
      logic [8:0] base;
      if (!rstn) return IDLE;
      if (data_sram_miss)      base = SALL;
      else if (m_raw())        base = RAWO;
      else if (npc_sel_ex)     base = REDIR;
      else if (m_stale)        base = DROPO;
      else if (inst_sram_miss) base = IMISS;
      else                     base = IDLE;
      return base | {8'b0, m_stale};
   endfunction

   // Advance the model with the inputs currently applied, then move to the next cycle.
   task automatic step();
      bit raw, redir;
      int wa;
      if (!rstn) begin
         for (int r = 0; r < 32; r++) ready[r] = tick;
         m_pend  = 1'b0;
         m_stale = 1'b0;
      end else if (!data_sram_miss) begin
         raw   = m_raw();
         redir = npc_sel_ex && !raw;
         wa    = int'(id_wa);
         if (id_valid && id_we && wa != 0 && !raw && !npc_sel_ex)
            if (ready[wa] < tick + 1 + int'(id_lat)) ready[wa] = tick + 1 + int'(id_lat);
         if (m_stale) begin
            if (!redir && !inst_sram_miss) begin
               m_stale = 1'b0;
               m_pend  = 1'b0;
            end
         end else if (m_pend) begin
            if (redir) m_stale = 1'b1;
            else if (!inst_sram_miss) m_pend = 1'b0;
         end else if (inst_sram_miss && !redir) begin
            m_pend = 1'b1;
         end
         tick++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rstn = 1'b1; id_valid = 1'b0; id_we = 1'b0; id_wa = '0; id_lat = '0;
      id_re = '0; id_ra = '0; npc_sel_ex = 1'b0; inst_sram_miss = 1'b0; data_sram_miss = 1'b0;
   endtask

   // Issue a producer, then hold a dependent reader in ID until it is released.
   task automatic run_dep(input int lat, input int rg, input int port, input int dmiss_n,
                          output int stalls, output int salls);
      stalls = 0;
      salls  = 0;
      set_idle();
      id_valid = 1'b1; id_we = 1'b1; id_wa = 5'(rg); id_lat = 3'(lat);
      #3;
      step();
      set_idle();
      id_valid = 1'b1; id_we = 1'b1; id_wa = 5'd10;
      id_re = 2'(1 << port); id_ra = 10'(rg) << (port * AW);
      for (int i = 0; i < 20; i++) begin
         data_sram_miss = (i >= 1 && i < 1 + dmiss_n);
         #3;
         if (obs[2]) salls++;
         else if (obs[6]) stalls++;
         else begin
            step();
            break;
         end
         step();
         if (i == 19) stalls = -1;
      end
      set_idle();
   endtask

   task automatic test_reset();
      set_idle();
      rstn = 1'b0; npc_sel_ex = 1'b1; inst_sram_miss = 1'b1; data_sram_miss = 1'b1;
      #3;
      n_checks++;
      if (obs !== IDLE) begin
         n_fail++; $display("FAIL reset_held obs=%b exp=%b", obs, IDLE);
      end
      step();
      set_idle();
      #3;
      n_checks++;
      if (obs !== IDLE) begin
         n_fail++; $display("FAIL reset_release obs=%b exp=%b", obs, IDLE);
      end
      step();
   endtask

   task automatic test_load_use();
      int st, sa;
      run_dep(1, 5, 0, 0, st, sa);
      n_checks++;
      if (st + sa !== 1) begin
         n_fail++; $display("FAIL load_use_lat1 stalls=%0d exp=1", st + sa);
      end
      run_dep(0, 5, 0, 0, st, sa);
      n_checks++;
      if (st + sa !== 0) begin
         n_fail++; $display("FAIL load_use_lat0 stalls=%0d exp=0", st + sa);
      end
   endtask

   task automatic test_divider();
      int st, sa;
      run_dep(4, 7, 1, 0, st, sa);
      n_checks++;
      if (st + sa !== 4) begin
         n_fail++; $display("FAIL div_lat4 stalls=%0d exp=4", st + sa);
      end
      run_dep(4, 7, 1, 3, st, sa);
      n_checks++;
      if (st + sa !== 7) begin
         n_fail++; $display("FAIL div_dmiss_total stalls=%0d exp=7", st + sa);
      end
      n_checks++;
      if (sa !== 3) begin
         n_fail++; $display("FAIL div_dmiss_stall_all cycles=%0d exp=3", sa);
      end
   endtask

   task automatic test_reg0();
      int st, sa;
      run_dep(4, 0, 0, 0, st, sa);
      n_checks++;
      if (st + sa !== 0) begin
         n_fail++; $display("FAIL reg0 stalls=%0d exp=0", st + sa);
      end
   endtask

   task automatic test_redirect_miss();
      logic [8:0] exp;
      for (int c = 1; c <= 7; c++) begin
         set_idle();
         inst_sram_miss = (c <= 5);
         npc_sel_ex     = (c == 2);
         case (c)
            1:       exp = IMISS;
            2:       exp = REDIR;
            7:       exp = IDLE;
            default: exp = DROPO;
         endcase
         #3;
         n_checks++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL redirect_miss_c%0d obs=%b exp=%b", c, obs, exp);
         end
         step();
      end
   endtask

   task automatic test_priority();
      set_idle();
      id_valid = 1'b1; id_we = 1'b1; id_wa = 5'd9; id_lat = 3'd4;
      #3;
      n_checks++;
      if (obs !== IDLE) begin
         n_fail++; $display("FAIL prio_issue obs=%b exp=%b", obs, IDLE);
      end
      step();
      set_idle();
      id_valid = 1'b1; id_we = 1'b1; id_wa = 5'd11; id_re = 2'b01; id_ra = 10'd9;
      npc_sel_ex = 1'b1; inst_sram_miss = 1'b1;
      #3;
      n_checks++;
      if (obs !== RAWO) begin
         n_fail++; $display("FAIL prio_raw obs=%b exp=%b", obs, RAWO);
      end
      step();
      data_sram_miss = 1'b1;
      #3;
      n_checks++;
      if (obs !== SALL) begin
         n_fail++; $display("FAIL prio_dmiss obs=%b exp=%b", obs, SALL);
      end
      step();
      for (int i = 0; i < 6; i++) begin
         set_idle();
         #3;
         n_checks++;
         if (obs !== IDLE) begin
            n_fail++; $display("FAIL prio_drain_%0d obs=%b exp=%b", i, obs, IDLE);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      set_idle();
      inst_sram_miss = 1'b1; id_valid = 1'b1; id_we = 1'b1; id_wa = 5'd3; id_lat = 3'd4;
      #3;
      n_checks++;
      if (obs !== IMISS) begin
         n_fail++; $display("FAIL rmid_miss obs=%b exp=%b", obs, IMISS);
      end
      step();
      set_idle();
      inst_sram_miss = 1'b1; npc_sel_ex = 1'b1;
      #3;
      n_checks++;
      if (obs !== REDIR) begin
         n_fail++; $display("FAIL rmid_redirect obs=%b exp=%b", obs, REDIR);
      end
      step();
      set_idle();
      inst_sram_miss = 1'b1; rstn = 1'b0;
      #3;
      n_checks++;
      if (obs !== IDLE) begin
         n_fail++; $display("FAIL rmid_reset obs=%b exp=%b", obs, IDLE);
      end
      step();
      set_idle();
      id_valid = 1'b1; id_we = 1'b1; id_wa = 5'd12; id_re = 2'b01; id_ra = 10'd3;
      #3;
      n_checks++;
      if (obs !== IDLE) begin
         n_fail++; $display("FAIL rmid_after obs=%b exp=%b", obs, IDLE);
      end
      step();
   endtask

   task automatic test_random();
      logic [8:0] exp, mask;
      for (int i = 0; i < 400; i++) begin
         rstn           = ($urandom_range(0, 49) != 0);
         id_valid       = ($urandom_range(0, 3) != 0);
         id_we          = ($urandom_range(0, 3) != 0);
         id_wa          = 5'($urandom_range(0, 7));
         id_lat         = 3'($urandom_range(0, MAX_LAT));
         id_re          = 2'($urandom_range(0, 3));
         id_ra          = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         npc_sel_ex     = ($urandom_range(0, 7) == 0);
         inst_sram_miss = ($urandom_range(0, 2) == 0);
         data_sram_miss = ($urandom_range(0, 7) == 0);
         #3;
         exp  = m_out();
         mask = (rstn && data_sram_miss) ? 9'h1FE : 9'h1FF;
         n_checks++;
         if ((obs & mask) !== (exp & mask)) begin
            n_fail++; $display("FAIL random_%0d obs=%b exp=%b", i, obs, exp);
         end
         step();
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      test_reset();
      test_load_use();
      test_divider();
      test_reg0();
      test_redirect_miss();
      test_priority();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
